rf_wb_queue: RTL
================

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, register address width; register (1<<ADDR_SIZE)-1 is PC, (1<<ADDR_SIZE)-2 is link register (LR).
REQ-003 SHALL have parameter DEPTH, default 4, queue entries, power of two, >=2.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 alu_valid / alu_ready  input / output  1 / 1  ALU write-back handshake.
REQ-008 alu_wa / alu_din  input  ADDR_SIZE / WIDTH  ALU destination and result.
REQ-009 mem_valid / mem_ready  input / output  1 / 1  load-return write-back handshake.
REQ-010 mem_wa / mem_din  input  ADDR_SIZE / WIDTH  load destination and data.
REQ-011 link  input  1  register-file link strobe, same signal driven to the register file.
REQ-012 wen / wa / din  output  1 / ADDR_SIZE / WIDTH  write port to the register file.
REQ-013 pend_mask  output  1<<ADDR_SIZE  bit i set while any queued entry targets register i.
REQ-014 empty / full  output  1 / 1  queue status.
REQ-015 err_link  output  1  sticky: link asserted while an LR write was queued.

Function
REQ-016 Queue SHALL be FIFO of {wa, din}, DEPTH entries, count 0..DEPTH.
REQ-017 alu_ready SHALL be (count < DEPTH); mem_ready SHALL be (count <= DEPTH-2); neither depends on any valid.
REQ-018 Transfer occurs on a source when valid & ready at rising clk.
REQ-019 Simultaneous ALU and MEM transfers SHALL both be enqueued, ALU entry ahead of MEM entry.
REQ-020 wen SHALL be (!empty & !link); wa/din SHALL be head entry combinationally; wa/din SHALL be 0 when empty.
REQ-021 Head SHALL be popped at rising clk when wen=1; while link=1 head SHALL be held unchanged (register file gives link priority).
REQ-022 Push and pop in same cycle: count_next = count + pushes - pops; full queue with pop SHALL still block alu_ready that cycle (ready is registered-count based).
REQ-023 Latency: entry pushed at edge N with empty queue and link=0 SHALL appear with wen=1 in cycle after edge N and be written at edge N+1.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 pend_mask SHALL be OR of decoded wa over valid entries, combinational from state; multiple entries to one register keep bit set until the last pops.
REQ-026 err_link SHALL set at rising clk when link=1 and pend_mask[LR]=1; cleared only by reset.
REQ-027 Writes to PC index SHALL be queued and issued like any other register.
REQ-028 empty = (count==0); full = (count==DEPTH).

Reset
REQ-029 reset=0 SHALL immediately force count=0, pointers=0, err_link=0, hence wen=0, wa=0, din=0, pend_mask=0, empty=1, full=0, alu_ready=1, mem_ready=1.
REQ-030 Reset mid-operation SHALL discard all queued entries; storage array contents need not be cleared.
REQ-031 First push SHALL be accepted on first rising clk after reset deasserts.

Structure
REQ-032 Shared package SHALL hold WIDTH, ADDR_SIZE defaults and PC_IDX / LR_IDX constants, shared with register-file block.
REQ-033 Storage plus pointers SHALL be one sub-module rf_wb_fifo (two write ports, one read port, count); rf_wb_queue adds readies, link gating, pend_mask, err_link.

Verification
REQ-034 Empty queue, alu push wa=3 din=0x11, link=0 -> next cycle wen=1 wa=3 din=0x11, pend_mask=0x0008, then empty=1.
REQ-035 Same-cycle alu (wa=1,0xA) and mem (wa=2,0xB) -> writes issue wa=1 then wa=2 on consecutive cycles.
REQ-036 Fill 4 entries with link=1 held -> full=1, alu_ready=0, mem_ready=0, wen=0; drop link -> 4 writes in order on 4 cycles.
REQ-037 Queue LR write (wa=14), assert link next cycle -> err_link=1, stays 1 until reset; head held during link.
REQ-038 Two entries to wa=5 queued -> pend_mask[5]=1 until second pops, then 0.
REQ-039 Reset asserted with 3 entries queued, mid-cycle -> wen=0, empty=1 immediately; post-reset push wa=7 issues normally.

Source files
------------

// File: rtl/rf_wb_queue_pkg.sv
// rf_wb_queue_pkg: defaults and special register indices
// shared by the write-back queue and the register file.
package rf_wb_queue_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int DEPTH_DEF     = 4;

  localparam int PC_IDX = (1 << ADDR_SIZE_DEF) - 1;
  localparam int LR_IDX = (1 << ADDR_SIZE_DEF) - 2;

  function automatic int lr_idx(input int asz);
    return (1 << asz) - 2;
  endfunction

  function automatic int pc_idx(input int asz);
    return (1 << asz) - 1;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: DEPTH-entry {wa, din} FIFO with two write ports
// (port a lands ahead of port b) and one read port.
module rf_wb_fifo
  import rf_wb_queue_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push_a,
  input  logic [ADDR_SIZE-1:0]               wa_a,
  input  logic [WIDTH-1:0]                   din_a,
  input  logic                               push_b,
  input  logic [ADDR_SIZE-1:0]               wa_b,
  input  logic [WIDTH-1:0]                   din_b,
  input  logic                               pop,
  output logic [ADDR_SIZE-1:0]               head_wa,
  output logic [WIDTH-1:0]                   head_din,
  output logic [CW-1:0]                      count,
  output logic [DEPTH-1:0][ADDR_SIZE-1:0]    slot_wa,
  output logic [DEPTH-1:0]                   slot_vld
);

  logic [ADDR_SIZE-1:0] wa_q  [DEPTH];
  logic [WIDTH-1:0]     din_q [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        b_ptr;

  assign b_ptr = wr_ptr + PW'(push_a);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      count  <= count + CW'(push_a) + CW'(push_b)
              - CW'(pop);
    end
  end

  // Storage is never reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push_a) begin
      wa_q[wr_ptr]  <= wa_a;
      din_q[wr_ptr] <= din_a;
    end
    if (push_b) begin
      wa_q[b_ptr]  <= wa_b;
      din_q[b_ptr] <= din_b;
    end
  end

  assign head_wa  = wa_q[rd_ptr];
  assign head_din = din_q[rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] off;
    assign off         = PW'(g) - rd_ptr;
    assign slot_vld[g] = {1'b0, off} < count;
    assign slot_wa[g]  = wa_q[g];
  end

endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: merges ALU and load-return write-backs into one
// register-file write port; yields to the link strobe.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_SIZE-1:0]        alu_wa,
  input  logic [WIDTH-1:0]            alu_din,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [ADDR_SIZE-1:0]        mem_wa,
  input  logic [WIDTH-1:0]            mem_din,
  input  logic                        link,
  output logic                        wen,
  output logic [ADDR_SIZE-1:0]        wa,
  output logic [WIDTH-1:0]            din,
  output logic [(1<<ADDR_SIZE)-1:0]   pend_mask,
  output logic                        empty,
  output logic                        full,
  output logic                        err_link
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int LR = lr_idx(ADDR_SIZE);

  logic                             push_a;
  logic                             push_b;
  logic [ADDR_SIZE-1:0]             head_wa;
  logic [WIDTH-1:0]                 head_din;
  logic [CW-1:0]                    count;
  logic [DEPTH-1:0][ADDR_SIZE-1:0]  slot_wa;
  logic [DEPTH-1:0]                 slot_vld;

  // Readies look only at the registered count, never at valids.
  assign alu_ready = count < CW'(DEPTH);
  assign mem_ready = count <= CW'(DEPTH - 2);
  assign push_a    = alu_valid & alu_ready;
  assign push_b    = mem_valid & mem_ready;

  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign wen   = !empty && !link;
  assign wa    = empty ? '0 : head_wa;
  assign din   = empty ? '0 : head_din;

  rf_wb_fifo #(
    .WIDTH     (WIDTH),
    .ADDR_SIZE (ADDR_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_a   (push_a),
    .wa_a     (alu_wa),
    .din_a    (alu_din),
    .push_b   (push_b),
    .wa_b     (mem_wa),
    .din_b    (mem_din),
    .pop      (wen),
    .head_wa  (head_wa),
    .head_din (head_din),
    .count    (count),
    .slot_wa  (slot_wa),
    .slot_vld (slot_vld)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) pend_mask[slot_wa[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_link <= 1'b0;
    end else if (link && pend_mask[LR]) begin
      err_link <= 1'b1;
    end
  end

endmodule
